// File: rtl/bcd_timekeeper_if.sv
// bcd_timekeeper_if: control inputs and BCD time outputs of the timekeeper.
// TWELVE_HOUR_EN adds the pm flag.
interface bcd_timekeeper_if;
  logic       run, adj_sec, adj_min, adj_hrs;
  logic [3:0] sec_u, min_u, hrs_u;
  logic [2:0] sec_d, min_d;
  logic [1:0] hrs_d;
  logic       minute_tick, sec_tick;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif
  modport master (
    output run, adj_sec, adj_min, adj_hrs,
    input  sec_u, sec_d, min_u, min_d, hrs_u, hrs_d, minute_tick, sec_tick
`ifdef TWELVE_HOUR_EN
    , input pm
`endif
  );
  modport slave (
    input  run, adj_sec, adj_min, adj_hrs,
    output sec_u, sec_d, min_u, min_d, hrs_u, hrs_d, minute_tick, sec_tick
`ifdef TWELVE_HOUR_EN
    , output pm
`endif
  );
endinterface

// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: BCD HH:MM:SS clock with a 1 Hz prescaler, adjust pulses and tick strobes.
// Define TWELVE_HOUR_EN for 12-hour mode with a pm flag.
module bcd_timekeeper #(
  parameter int CLK_HZ = 31_500_000
) (
  input logic clk,
  input logic reset_n,
  bcd_timekeeper_if.slave t
);
  localparam int CNT_W = $clog2(CLK_HZ);
`ifdef TWELVE_HOUR_EN
  localparam logic [1:0] H0_D = 2'd1, LAST_D = 2'd1, WRAP_D = 2'd0;
  localparam logic [3:0] H0_U = 4'd2, LAST_U = 4'd2, WRAP_U = 4'd1;
`else
  localparam logic [1:0] H0_D = 2'd0, LAST_D = 2'd2, WRAP_D = 2'd0;
  localparam logic [3:0] H0_U = 4'd0, LAST_U = 4'd3, WRAP_U = 4'd0;
`endif
  logic [CNT_W-1:0] cnt;
  logic pending, tick, adj, apply, s59, m59, inc_s, inc_m, inc_h;
  always_comb begin
    tick  = t.run && cnt == CNT_W'(CLK_HZ - 1);
    adj   = t.adj_sec || t.adj_min || t.adj_hrs;
    // any adjust pulse wins the cycle; the tick waits in pending
    apply = (tick || pending) && !adj;
    s59   = t.sec_d == 3'd5 && t.sec_u == 4'd9;
    m59   = t.min_d == 3'd5 && t.min_u == 4'd9;
    inc_s = apply || t.adj_sec;
    inc_m = (apply && s59) || t.adj_min;
    inc_h = (apply && s59 && m59) || t.adj_hrs;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt           <= '0;
      pending       <= 1'b0;
      t.sec_u       <= 4'd0;
      t.sec_d       <= 3'd0;
      t.min_u       <= 4'd0;
      t.min_d       <= 3'd0;
      t.hrs_u       <= H0_U;
      t.hrs_d       <= H0_D;
      t.sec_tick    <= 1'b0;
      t.minute_tick <= 1'b0;
`ifdef TWELVE_HOUR_EN
      t.pm          <= 1'b0;
`endif
    end else begin
      if (t.run) cnt <= tick ? '0 : cnt + 1'b1;
      pending       <= adj && (tick || pending);
      t.sec_tick    <= apply;
      t.minute_tick <= inc_m;
      if (inc_s) begin
        t.sec_u <= t.sec_u == 4'd9 ? 4'd0 : t.sec_u + 4'd1;
        if (t.sec_u == 4'd9) t.sec_d <= t.sec_d == 3'd5 ? 3'd0 : t.sec_d + 3'd1;
      end
      if (inc_m) begin
        t.min_u <= t.min_u == 4'd9 ? 4'd0 : t.min_u + 4'd1;
        if (t.min_u == 4'd9) t.min_d <= t.min_d == 3'd5 ? 3'd0 : t.min_d + 3'd1;
      end
      if (inc_h) begin
        if (t.hrs_d == LAST_D && t.hrs_u == LAST_U) begin
          t.hrs_d <= WRAP_D;
          t.hrs_u <= WRAP_U;
        end else if (t.hrs_u == 4'd9) begin
          t.hrs_d <= t.hrs_d + 2'd1;
          t.hrs_u <= 4'd0;
        end else t.hrs_u <= t.hrs_u + 4'd1;
`ifdef TWELVE_HOUR_EN
        if (t.hrs_d == 2'd1 && t.hrs_u == 4'd1) t.pm <= ~t.pm;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper: directed and randomized checks of bcd_timekeeper against a
// seconds-of-day behavioural model.
module tb_bcd_timekeeper;
  localparam int HZ = 4;
`ifdef TWELVE_HOUR_EN
  localparam int H0 = 12, HS = 11, PM1 = 1, H13 = 1;
`else
  localparam int H0 = 0, HS = 23, PM1 = 0, H13 = 13;
`endif
  logic clk = 1'b0, reset_n = 1'b0, chk = 1'b0, pmv;
  int tests = 0, fails = 0;
  int mh, mm, ms, mph, h24, tot;
  bit mpm, mpend, mst, mmt, tk;
  bcd_timekeeper_if bus();
  bcd_timekeeper #(.CLK_HZ(HZ)) dut (.clk(clk), .reset_n(reset_n), .t(bus.slave));
  always #5 clk = ~clk;
`ifdef TWELVE_HOUR_EN
  assign pmv = bus.pm;
`else
  assign pmv = 1'b0;
`endif
  function automatic logic [31:0] pk(int h, int m, int s, bit st, bit mt, bit pm);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            2'b0, st, mt, 3'b0, pm};
  endfunction
  function automatic logic [31:0] dv();
    return {4'(bus.hrs_d), bus.hrs_u, 4'(bus.min_d), bus.min_u, 4'(bus.sec_d), bus.sec_u,
            2'b0, bus.sec_tick, bus.minute_tick, 3'b0, pmv};
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (HHMMSS_tick_pm)", name, got, exp);
    end
  endtask
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mh = H0; mm = 0; ms = 0; mpm = 0; mph = 0; mpend = 0; mst = 0; mmt = 0;
    end else begin
      tk = bus.run && mph == HZ - 1;
      if (bus.run) mph = (mph + 1) % HZ;
      mst = 0;
      mmt = 0;
      if (bus.adj_sec || bus.adj_min || bus.adj_hrs) begin
        if (bus.adj_sec) ms = (ms + 1) % 60;
        if (bus.adj_min) begin mm = (mm + 1) % 60; mmt = 1; end
        if (bus.adj_hrs) begin
`ifdef TWELVE_HOUR_EN
          mh = mh % 12 + 1;
          if (mh == 12) mpm = !mpm;
`else
          mh = (mh + 1) % 24;
`endif
        end
        mpend = tk || mpend;
      end else if (tk || mpend) begin
`ifdef TWELVE_HOUR_EN
        h24 = mh % 12 + (mpm ? 12 : 0);
`else
        h24 = mh;
`endif
        tot = (h24 * 3600 + mm * 60 + ms + 1) % 86400;
        mmt = (tot / 60) % 60 != mm;
        ms = tot % 60;
        mm = (tot / 60) % 60;
        h24 = tot / 3600;
`ifdef TWELVE_HOUR_EN
        mh = h24 % 12 == 0 ? 12 : h24 % 12;
        mpm = h24 >= 12;
`else
        mh = h24;
`endif
        mst = 1;
        mpend = 0;
      end
    end
  end
  always @(negedge clk) if (chk) check("model", dv(), pk(mh, mm, ms, mst, mmt, mpm));
  task automatic do_reset();
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
  endtask
  task automatic pulses(int n_s, int n_m, int n_h);
    for (int i = 0; i < 60; i++) begin
      if (i < n_s || i < n_m || i < n_h) begin
        bus.adj_sec = i < n_s;
        bus.adj_min = i < n_m;
        bus.adj_hrs = i < n_h;
        @(posedge clk); #2;
      end
    end
    {bus.adj_sec, bus.adj_min, bus.adj_hrs} = 3'b0;
  endtask
  initial begin
    {bus.run, bus.adj_sec, bus.adj_min, bus.adj_hrs} = 4'b0;
    @(posedge clk); #2 check("reset_state", dv(), pk(H0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    chk = 1'b1;
    bus.run = 1'b1;
    repeat (4) @(posedge clk); #2 check("sec_1", dv(), pk(H0, 0, 1, 1, 0, 0));
    repeat (4) @(posedge clk); #2 check("sec_2", dv(), pk(H0, 0, 2, 1, 0, 0));
    repeat (4) @(posedge clk); #2 check("sec_3", dv(), pk(H0, 0, 3, 1, 0, 0));
    repeat (2) @(posedge clk); #2 reset_n = 1'b0;
    #1 check("async_reset", dv(), pk(H0, 0, 0, 0, 0, 0));
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(posedge clk); #2 bus.run = 1'b0;
    repeat (20) @(posedge clk); #2 check("frozen", dv(), pk(H0, 0, 0, 0, 0, 0));
    bus.run = 1'b1;
    repeat (2) @(posedge clk); #2 check("resume", dv(), pk(H0, 0, 1, 1, 0, 0));
    bus.run = 1'b0;
    do_reset();
    pulses(59, 59, HS);
    check("preload", dv(), pk(HS, 59, 59, 0, 1, 0));
    bus.run = 1'b1;
    repeat (4) @(posedge clk); #2 check("rollover", dv(), pk(H0, 0, 0, 1, 1, PM1));
    @(posedge clk); #2 check("strobe_drop", dv(), pk(H0, 0, 0, 0, 0, PM1));
    bus.run = 1'b0;
    do_reset();
    pulses(59, 59, 12);
    bus.run = 1'b1;
    repeat (4) @(posedge clk); #2 check("hour_carry", dv(), pk(H13, 0, 0, 1, 1, PM1));
    bus.run = 1'b0;
    do_reset();
    pulses(0, 59, 0);
    check("min_59", dv(), pk(H0, 59, 0, 0, 1, 0));
    pulses(0, 1, 0);
    check("adj_min_wrap", dv(), pk(H0, 0, 0, 0, 1, 0));
    pulses(0, 0, HS);
    check("hrs_last", dv(), pk(HS, 0, 0, 0, 0, 0));
    pulses(0, 0, 1);
    check("adj_hrs_wrap", dv(), pk(H0, 0, 0, 0, 0, PM1));
    bus.run = 1'b1;
    do_reset();
    repeat (20) @(posedge clk); #2 check("at_5", dv(), pk(H0, 0, 5, 1, 0, 0));
    repeat (3) @(posedge clk); #2 bus.adj_sec = 1'b1;
    @(posedge clk); #2 bus.adj_sec = 1'b0;
    check("collide", dv(), pk(H0, 0, 6, 0, 0, 0));
    check("pending_set", 32'(dut.pending), 32'd1);
    @(posedge clk); #2 check("pending_apply", dv(), pk(H0, 0, 7, 1, 0, 0));
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      bus.run = $urandom_range(0, 9) != 0;
      bus.adj_sec = $urandom_range(0, 5) == 0;
      bus.adj_min = $urandom_range(0, 5) == 0;
      bus.adj_hrs = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
    end
    {bus.run, bus.adj_sec, bus.adj_min, bus.adj_hrs} = 4'b0;
    @(posedge clk); #2 chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
